arbiter_referee: RTL and testbench



---
 rtl/arbiter_referee.sv | 183 ++++++++++++++++++
 tb/tb_arbiter_referee.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_referee.sv
// Arbiter Game referee: first button edge after the countdown wins, any earlier edge is a foul; REACTION_TIMER_EN adds reaction_ms_out.
// Latency: pin sampled at edge k -> press edge after k+1 -> FSM moves at k+2 -> result outputs after k+3; round_end_out after HOLD_COUNT cycles of hold.
// No backpressure: buttons are free-running; presses outside WAIT_CD/ARMED are dropped, and a held button never re-triggers.
module arbiter_referee #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int HOLD_COUNT = CLOCK_FREQ * 2,
    parameter int TICK_COUNT = CLOCK_FREQ / 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cd_done_in,
    input  logic       btn_a_in,
    input  logic       btn_b_in,
    output logic       win_a_out,
    output logic       win_b_out,
    output logic       foul_a_out,
    output logic       foul_b_out,
    output logic       result_valid_out,
    output logic       round_end_out
`ifdef REACTION_TIMER_EN
    ,
    output logic [9:0] reaction_ms_out
`endif
);

    localparam int HOLD_CW = $clog2(HOLD_COUNT);

    if (HOLD_COUNT < 2) begin : g_hold_chk
        $error("HOLD_COUNT must be at least 2");
    end

    typedef enum logic [1:0] {WAIT_CD, ARMED, RESULT, WAIT_CLEAR} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               a_s1, a_s2, a_s2_d;
    logic               b_s1, b_s2, b_s2_d;
    logic               press_a, press_b, any_press;
    logic [HOLD_CW-1:0] hold_cnt;
    logic               hold_done;
    logic               res_win_a, res_win_b, res_foul_a, res_foul_b;
    logic               valid_nxt;
    logic               round_end_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {a_s1, a_s2, a_s2_d} <= '0;
            {b_s1, b_s2, b_s2_d} <= '0;
        end else begin
            a_s1   <= btn_a_in;
            a_s2   <= a_s1;
            a_s2_d <= a_s2;
            b_s1   <= btn_b_in;
            b_s2   <= b_s1;
            b_s2_d <= b_s2;
        end
    end

    assign press_a   = a_s2 & ~a_s2_d;
    assign press_b   = b_s2 & ~b_s2_d;
    assign any_press = press_a | press_b;
    assign hold_done = (state == RESULT) && (hold_cnt == HOLD_CW'(HOLD_COUNT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_CD;
        end else begin
            state <= state_nxt;
        end
    end

    // A press seen together with cd_done_in in WAIT_CD is still a foul.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_CD: begin
                if (any_press) begin
                    state_nxt = RESULT;
                end else if (cd_done_in) begin
                    state_nxt = ARMED;
                end
            end
            ARMED:      if (any_press)   state_nxt = RESULT;
            RESULT:     if (hold_done)   state_nxt = WAIT_CLEAR;
            WAIT_CLEAR: if (!cd_done_in) state_nxt = WAIT_CD;
            default:    state_nxt = WAIT_CD;
        endcase
    end

    // Leaving WAIT_CLEAR clears the display on the same edge the FSM returns to WAIT_CD.
    always_comb begin
        valid_nxt     = (state == RESULT) || ((state == WAIT_CLEAR) && cd_done_in);
        round_end_nxt = hold_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {res_win_a, res_win_b, res_foul_a, res_foul_b} <= '0;
            hold_cnt <= '0;
        end else begin
            if ((state == WAIT_CD) && any_press) begin
                res_win_a  <= 1'b0;
                res_win_b  <= 1'b0;
                res_foul_a <= press_a;
                res_foul_b <= press_b;
            end else if ((state == ARMED) && any_press) begin
                res_win_a  <= press_a;
                res_win_b  <= press_b;
                res_foul_a <= 1'b0;
                res_foul_b <= 1'b0;
            end
            hold_cnt <= ((state == RESULT) && !hold_done) ? hold_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_a_out        <= 1'b0;
            win_b_out        <= 1'b0;
            foul_a_out       <= 1'b0;
            foul_b_out       <= 1'b0;
            result_valid_out <= 1'b0;
            round_end_out    <= 1'b0;
        end else begin
            win_a_out        <= valid_nxt & res_win_a;
            win_b_out        <= valid_nxt & res_win_b;
            foul_a_out       <= valid_nxt & res_foul_a;
            foul_b_out       <= valid_nxt & res_foul_b;
            result_valid_out <= valid_nxt;
            round_end_out    <= round_end_nxt;
        end
    end

`ifdef REACTION_TIMER_EN
    localparam int TICK_CW = $clog2(TICK_COUNT + 1);

    if (TICK_COUNT < 1) begin : g_tick_chk
        $error("TICK_COUNT must be at least 1");
    end

    logic [TICK_CW-1:0] tick_cnt;
    logic [9:0]         ms_cnt;
    logic [9:0]         res_ms;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
            res_ms   <= '0;
        end else begin
            if ((state == WAIT_CD) && (state_nxt == ARMED)) begin
                tick_cnt <= '0;
                ms_cnt   <= '0;
            end else if (state == ARMED) begin
                if (tick_cnt == TICK_CW'(TICK_COUNT - 1)) begin
                    tick_cnt <= '0;
                    if (ms_cnt != 10'd999) ms_cnt <= ms_cnt + 10'd1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
            if ((state == WAIT_CD) && any_press) begin
                res_ms <= '0;
            end else if ((state == ARMED) && any_press) begin
                res_ms <= ms_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reaction_ms_out <= '0;
        end else begin
            reaction_ms_out <= valid_nxt ? res_ms : 10'd0;
        end
    end
`else
    if (TICK_COUNT < 0) begin : g_tick_chk
        $error("TICK_COUNT must not be negative");
    end
`endif

endmodule

// File: tb/tb_arbiter_referee.sv
// Bench for arbiter_referee: table of single-round scenarios plus hand-written held-button and mid-hold reset sequences.
// Expected results are queued when the deciding pin is driven and checked when result_valid_out rises.
`timescale 1ns/1ps
module tb_arbiter_referee;

    localparam int HOLD = 8;
    localparam int TICK = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cd_done_in = 1'b0;
    logic btn_a_in = 1'b0;
    logic btn_b_in = 1'b0;
    logic win_a_out, win_b_out, foul_a_out, foul_b_out, result_valid_out, round_end_out;
`ifdef REACTION_TIMER_EN
    logic [9:0] reaction_ms_out;
`endif

    arbiter_referee #(
        .HOLD_COUNT(HOLD),
        .TICK_COUNT(TICK)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cd_done_in       (cd_done_in),
        .btn_a_in         (btn_a_in),
        .btn_b_in         (btn_b_in),
        .win_a_out        (win_a_out),
        .win_b_out        (win_b_out),
        .foul_a_out       (foul_a_out),
        .foul_b_out       (foul_b_out),
        .result_valid_out (result_valid_out),
        .round_end_out    (round_end_out)
`ifdef REACTION_TIMER_EN
        ,
        .reaction_ms_out  (reaction_ms_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cd_at;
        int a_at;
        int a_len;
        int b_at;
        int b_len;
        bit wa;
        bit wb;
        bit fa;
        bit fb;
        int ms;
    } vec_t;

    typedef struct {
        bit wa;
        bit wb;
        bit fa;
        bit fb;
        int ms;
        int due;
    } exp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic cd_q = 1'b0;
    exp_t sb[$];
    int   re_due = 0;
    bit   re_pending = 1'b0;
    bit   re_prev = 1'b0;
    logic valid_prev = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        cd_q <= cd_done_in;
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Deciding pin is driven at this negedge; result is due 4 posedges later.
    task automatic expect_result(input bit wa, input bit wb, input bit fa, input bit fb, input int ms);
        exp_t e;
        e.wa  = wa;
        e.wb  = wb;
        e.fa  = fa;
        e.fb  = fb;
        e.ms  = ms;
        e.due = cyc + 4;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (result_valid_out && !valid_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", int'(result_valid_out), 0);
                end else begin
                    e = sb.pop_front();
                    check("result_cycle", cyc, e.due);
                    check("win_a", int'(win_a_out), int'(e.wa));
                    check("win_b", int'(win_b_out), int'(e.wb));
                    check("foul_a", int'(foul_a_out), int'(e.fa));
                    check("foul_b", int'(foul_b_out), int'(e.fb));
`ifdef REACTION_TIMER_EN
                    check("reaction_ms", int'(reaction_ms_out), e.ms);
`endif
                    re_due     = e.due + HOLD - 1;
                    re_pending = 1'b1;
                end
            end
            if (round_end_out) begin
                if (!re_pending) begin
                    check("unexpected_round_end", int'(round_end_out), 0);
                end else begin
                    check("round_end_cycle", cyc, re_due);
                    re_pending = 1'b0;
                end
            end
            if (re_prev && !cd_q) begin
                check("clear_after_round_end",
                      int'({result_valid_out, win_a_out, win_b_out, foul_a_out, foul_b_out}), 0);
            end
            re_prev    = round_end_out;
            valid_prev = result_valid_out;
        end else begin
            re_prev    = 1'b0;
            valid_prev = 1'b0;
        end
    end

    task automatic check_all_zero(input string name);
        check(name, int'({result_valid_out, win_a_out, win_b_out, foul_a_out, foul_b_out, round_end_out}), 0);
`ifdef REACTION_TIMER_EN
        check({name, "_ms"}, int'(reaction_ms_out), 0);
`endif
    endtask

    task automatic finish_round(input bit keep_a);
        for (int i = 0; i < HOLD + 40 && (re_pending || sb.size() != 0); i++) @(negedge clk);
        if (re_pending || sb.size() != 0) begin
            check("round_end_timeout", sb.size() + int'(re_pending), 0);
            sb.delete();
            re_pending = 1'b0;
        end
        @(negedge clk);
        cd_done_in = 1'b0;
        btn_b_in   = 1'b0;
        if (!keep_a) btn_a_in = 1'b0;
        @(negedge clk);
        check_all_zero("cleared_after_cd_drop");
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int dec;
        int last;
        if (v.a_at < 0)      dec = v.b_at;
        else if (v.b_at < 0) dec = v.a_at;
        else                 dec = (v.a_at < v.b_at) ? v.a_at : v.b_at;
        last = v.cd_at;
        if (v.a_at + v.a_len > last) last = v.a_at + v.a_len;
        if (v.b_at + v.b_len > last) last = v.b_at + v.b_len;
        for (int t = 0; t <= last + 1; t++) begin
            @(negedge clk);
            cd_done_in = (v.cd_at >= 0) && (t >= v.cd_at);
            btn_a_in   = (v.a_at >= 0) && (t >= v.a_at) && (t < v.a_at + v.a_len);
            btn_b_in   = (v.b_at >= 0) && (t >= v.b_at) && (t < v.b_at + v.b_len);
            if (t == dec) expect_result(v.wa, v.wb, v.fa, v.fb, v.ms);
        end
        finish_round(1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t vecs[11];
        //          cd    a  alen   b  blen  wa wb fa fb  ms
        vecs[0]  = '{10,   20,  3,  -1,  0,  1, 0, 0, 0,   2};
        vecs[1]  = '{ 3,   -1,  0,  30,  2,  0, 1, 0, 0,   7};
        vecs[2]  = '{-1,   -1,  0,   5,  1,  0, 0, 0, 1,   0};
        vecs[3]  = '{-1,    4,  2,  -1,  0,  0, 0, 1, 0,   0};
        vecs[4]  = '{-1,    6,  2,   6,  2,  0, 0, 1, 1,   0};
        vecs[5]  = '{ 2,   10,  3,  10,  3,  1, 1, 0, 0,   2};
        vecs[6]  = '{ 6,    5,  2,  -1,  0,  1, 0, 0, 0,   0};
        vecs[7]  = '{ 7,    5,  2,  -1,  0,  0, 0, 1, 0,   0};
        vecs[8]  = '{ 2,   12,  3,  13,  3,  1, 0, 0, 0,   2};
        vecs[9]  = '{ 2,   42,  2,  -1,  0,  1, 0, 0, 0,  10};
        vecs[10] = '{ 2, 5002,  2,  -1,  0,  1, 0, 0, 0, 999};

        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        check("reset_round_end", int'(round_end_out), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // A pressed during one round and held into the next must not count; B wins alone.
        @(negedge clk);
        cd_done_in = 1'b1;
        repeat (4) @(negedge clk);
        btn_a_in = 1'b1;
        expect_result(1'b1, 1'b0, 1'b0, 1'b0, 1);
        finish_round(1'b1);
        @(negedge clk);
        cd_done_in = 1'b1;
        repeat (12) @(negedge clk);
        btn_b_in = 1'b1;
        expect_result(1'b0, 1'b1, 1'b0, 1'b0, 3);
        finish_round(1'b0);

        // Reset during the hold: outputs drop at once and the round never ends.
        @(negedge clk);
        cd_done_in = 1'b1;
        repeat (4) @(negedge clk);
        btn_a_in = 1'b1;
        expect_result(1'b1, 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 20 && !result_valid_out; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("valid_before_reset", int'(result_valid_out), 1);
        #2;
        reset      = 1'b0;
        cd_done_in = 1'b0;
        btn_a_in   = 1'b0;
        re_pending = 1'b0;
        sb.delete();
        #1;
        check_all_zero("async_reset_outputs");
        @(negedge clk);
        reset = 1'b1;
        repeat (HOLD + 4) @(negedge clk);
        check_all_zero("idle_after_reset");
        btn_b_in = 1'b1;
        expect_result(1'b0, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        btn_b_in = 1'b0;
        finish_round(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
